// File: rtl/led_pattern_gen_pkg.sv
// Shared mode codes and default sizing for the LED sequencer.
// The MODE encoding here must match whatever control logic drives the MODE pins.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'd0,
    MODE_FILL_DRAIN = 2'd1,
    MODE_CHASE      = 2'd2,
    MODE_PINGPONG   = 2'd3
  } led_mode_e;

  localparam int LED_WIDTH_DEFAULT = 8;
  localparam int LED_DIV_W_DEFAULT = 24;

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// led_step_prescaler: clock-enable generator, TICK once every DIV+1 enabled cycles.
// The count is held (not cleared) while EN is low.
module led_step_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  output logic             TICK
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Using >= means lowering DIV below the running count ticks on the next enabled cycle.
  always_comb begin
    TICK  = EN && (cnt_q >= DIV);
    cnt_d = cnt_q;
    if (EN) begin
      cnt_d = TICK ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: WIDTH-bit LED sequencer with four patterns, mirroring, freeze and step/wrap strobes.
// Build option LEDPAT_ACTIVE_LOW_EN inverts Q for sink-driven LEDs (Q resets to all-ones).
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH_DEFAULT,
  parameter int DIV_W = LED_DIV_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             DIR,
  input  logic [DIV_W-1:0] DIV,
  output logic [WIDTH-1:0] Q,
  output logic             STEP,
  output logic             WRAP
);

`ifdef LEDPAT_ACTIVE_LOW_EN
  localparam logic ACTIVE_LOW = 1'b1;
`else
  localparam logic ACTIVE_LOW = 1'b0;
`endif

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_RESET  = {WIDTH{ACTIVE_LOW}};

  logic             tick;
  led_mode_e        mode_in;
  led_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] p_q, p_d, p_next;
  logic             phase_q, phase_d, phase_next;
  logic             wrap_next;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  led_step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .DIV  (DIV),
    .TICK (tick)
  );

  assign mode_in = led_mode_e'(MODE);

  // Next pattern in the LSB frame; DIR mirroring is applied only at the output.
  always_comb begin
    p_next     = p_q;
    phase_next = phase_q;
    wrap_next  = 1'b0;
    case (mode_q)
      MODE_FILL: begin
        if (p_q == ALL_ONES) begin
          p_next    = '0;
          wrap_next = 1'b1;
        end else begin
          p_next = (p_q << 1) | ONE;
        end
      end
      MODE_FILL_DRAIN: begin
        if (!phase_q) begin
          if (p_q == ALL_ONES) begin
            p_next     = p_q << 1;
            phase_next = 1'b1;
          end else begin
            p_next = (p_q << 1) | ONE;
          end
        end else begin
          p_next = p_q << 1;
          if (p_next == '0) begin
            phase_next = 1'b0;
            wrap_next  = 1'b1;
          end
        end
      end
      MODE_CHASE: begin
        if (p_q == '0 || p_q[WIDTH-1]) begin
          p_next    = ONE;
          wrap_next = p_q[WIDTH-1];
        end else begin
          p_next = p_q << 1;
        end
      end
      MODE_PINGPONG: begin
        // Direction flips on reaching an end so the end value is shown only once.
        if (p_q == '0) begin
          p_next     = ONE;
          phase_next = 1'b0;
        end else if (!phase_q) begin
          p_next = p_q << 1;
          if (p_next[WIDTH-1]) phase_next = 1'b1;
        end else begin
          p_next = p_q >> 1;
          if (p_next[0]) begin
            phase_next = 1'b0;
            wrap_next  = 1'b1;
          end
        end
      end
      default: begin
        p_next = ONE;
      end
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    p_d     = p_q;
    phase_d = phase_q;
    q_d     = q_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (tick) begin
      step_d = 1'b1;
      if (mode_in != mode_q) begin
        mode_d  = mode_in;
        p_d     = ONE;
        phase_d = 1'b0;
      end else begin
        p_d     = p_next;
        phase_d = phase_next;
        wrap_d  = wrap_next;
      end
      q_d = (DIR ? bitrev(p_d) : p_d) ^ {WIDTH{ACTIVE_LOW}};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q  <= MODE_FILL;
      p_q     <= '0;
      phase_q <= 1'b0;
      q_q     <= Q_RESET;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      p_q     <= p_d;
      phase_q <= phase_d;
      q_q     <= q_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign STEP = step_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WIDTH=8): expected steps are queued as stimulus
// is applied and popped whenever the DUT raises STEP.
module tb_led_pattern_gen;

`ifdef LEDPAT_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic       wrap;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic        dir;
  logic [23:0] div;
  logic [7:0]  q_out;
  logic        step_out;
  logic        wrap_out;

  exp_t       exp_q[$];
  int         total_checks;
  int         bad_checks;
  logic [7:0] last_q;
  int         used;

  led_pattern_gen #(.WIDTH(8), .DIV_W(24)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .EN   (en),
    .MODE (mode),
    .DIR  (dir),
    .DIV  (div),
    .Q    (q_out),
    .STEP (step_out),
    .WRAP (wrap_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total_checks++;
    if (got !== expv) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic d, input logic [23:0] dv);
    en   = e;
    mode = m;
    dir  = d;
    div  = dv;
  endtask

  task automatic expectStep(input logic [7:0] v, input logic w);
    exp_t e;
    e.q    = v;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] fill_val(input int n);
    logic [7:0] v;
    v = (n >= 9) ? 8'h00 : 8'((1 << n) - 1);
    return v;
  endfunction

  function automatic logic [7:0] pp_val(input int j);
    int pos;
    pos = j % 14;
    return (pos <= 7) ? 8'(1 << pos) : 8'(1 << (14 - pos));
  endfunction

  // One clock; any STEP seen is matched against the head of the scoreboard.
  task automatic clock_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    checkOutput("wrap_without_step", {31'b0, wrap_out & ~step_out}, 32'd0);
    if (step_out) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_step", {31'b0, step_out}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("q", {24'b0, q_out}, {24'b0, e.q ^ INV});
        checkOutput("wrap", {31'b0, wrap_out}, {31'b0, e.wrap});
        last_q = e.q ^ INV;
      end
    end
  endtask

  task automatic run_until_empty(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      clock_cycle();
      cycles++;
    end
    if (exp_q.size() > 0) begin
      checkOutput("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t;
    total_checks = 0;
    bad_checks   = 0;
    last_q       = INV;
    rst_n        = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", {24'b0, q_out}, {24'b0, INV});
    checkOutput("reset_step", {31'b0, step_out}, 32'd0);
    checkOutput("reset_wrap", {31'b0, wrap_out}, 32'd0);
    rst_n = 1'b1;

    // FILL, every cycle: 01..FF,00 then 01..
    applyStimulus(1'b1, 2'd0, 1'b0, 24'd0);
    for (int i = 0; i < 18; i++) expectStep(fill_val((i % 9) + 1), (i % 9) == 8);
    run_until_empty(40, used);
    checkOutput("t1_cycles", used, 32'd18);

    // FILL_DRAIN from a mode change: 01..FF,FE..80,00 then 01
    applyStimulus(1'b1, 2'd1, 1'b0, 24'd0);
    for (int j = 0; j < 17; j++) begin
      int m;
      m = j % 16;
      if (m < 8) t = 8'((1 << (m + 1)) - 1);
      else       t = 8'hFF << (m - 7);
      expectStep(t, m == 15);
    end
    run_until_empty(40, used);

    // PINGPONG: 01..80,40..01 with no repeated end value
    applyStimulus(1'b1, 2'd3, 1'b0, 24'd0);
    for (int j = 0; j < 16; j++) expectStep(pp_val(j), (j % 14 == 0) && j > 0);
    run_until_empty(40, used);
    checkOutput("t2_pp_cycles", used, 32'd16);

    // DIV=3 with a freeze in the middle of a count
    applyStimulus(1'b1, 2'd3, 1'b0, 24'd3);
    for (int j = 16; j < 19; j++) expectStep(pp_val(j), 1'b0);
    for (int c = 1; c <= 4; c++) begin
      clock_cycle();
      checkOutput("t3_step_a", {31'b0, step_out}, {31'b0, c == 4});
    end
    for (int c = 1; c <= 2; c++) begin
      clock_cycle();
      checkOutput("t3_step_b", {31'b0, step_out}, 32'd0);
    end
    en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      clock_cycle();
      checkOutput("t3_frozen_step", {31'b0, step_out}, 32'd0);
      checkOutput("t3_frozen_q", {24'b0, q_out}, {24'b0, 8'h04 ^ INV});
    end
    en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      clock_cycle();
      checkOutput("t3_resume", {31'b0, step_out}, {31'b0, c == 2});
    end
    for (int c = 1; c <= 4; c++) begin
      clock_cycle();
      checkOutput("t3_step_c", {31'b0, step_out}, {31'b0, c == 4});
    end
    repeat (2) clock_cycle();
    // Lowering DIV below the running count ticks on the very next cycle.
    div = 24'd1;
    expectStep(pp_val(19), 1'b0);
    clock_cycle();
    checkOutput("t3_div_lowered", {31'b0, step_out}, 32'd1);
    checkOutput("t3_queue_empty", exp_q.size(), 32'd0);

    // CHASE mirrored: 80,40..01,80; then switch to FILL mid-run
    applyStimulus(1'b1, 2'd2, 1'b1, 24'd0);
    for (int k = 0; k < 10; k++) expectStep(8'h80 >> (k % 8), (k % 8 == 0) && k > 0);
    run_until_empty(40, used);
    mode = 2'd0;
    for (int n = 1; n <= 3; n++) begin
      t = 8'hFF << (8 - n);
      expectStep(t, 1'b0);
    end
    run_until_empty(20, used);

    // Async reset between edges at Q=1F
    dir = 1'b0;
    expectStep(8'h0F, 1'b0);
    expectStep(8'h1F, 1'b0);
    run_until_empty(20, used);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_q", {24'b0, q_out}, {24'b0, INV});
    checkOutput("t5_async_step", {31'b0, step_out}, 32'd0);
    checkOutput("t5_async_wrap", {31'b0, wrap_out}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    expectStep(8'h01, 1'b0);
    expectStep(8'h03, 1'b0);
    run_until_empty(20, used);
    checkOutput("t5_restart_cycles", used, 32'd2);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
